// File: rtl/drw_mem_arb_if.sv
// Draw-engine memory arbiter bus: requester-side burst requests plus the shared VRAM address port.
interface drw_mem_arb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 8
);
  logic [2:0]        REQ;
  logic [ADDR_W-1:0] ADDR0;
  logic [ADDR_W-1:0] ADDR1;
  logic [ADDR_W-1:0] ADDR2;
  logic [LEN_W-1:0]  LEN0;
  logic [LEN_W-1:0]  LEN1;
  logic [LEN_W-1:0]  LEN2;
  logic [2:0]        GNT;
  logic              WR_URGENT;
  logic              M_REQ;
  logic [ADDR_W-1:0] M_ADDR;
  logic [LEN_W-1:0]  M_LEN;
  logic              M_WRITE;
  logic [1:0]        M_ID;
  logic              M_ACK;
  logic              M_RDONE;
  logic              M_WDONE;
  logic              BUSY;

  // Environment side: requesters and the memory port model
  modport master (
    output REQ, ADDR0, ADDR1, ADDR2, LEN0, LEN1, LEN2, WR_URGENT,
    output M_ACK, M_RDONE, M_WDONE,
    input  GNT, M_REQ, M_ADDR, M_LEN, M_WRITE, M_ID, BUSY
  );

  // Arbiter side
  modport slave (
    input  REQ, ADDR0, ADDR1, ADDR2, LEN0, LEN1, LEN2, WR_URGENT,
    input  M_ACK, M_RDONE, M_WDONE,
    output GNT, M_REQ, M_ADDR, M_LEN, M_WRITE, M_ID, BUSY
  );
endinterface

// File: rtl/drw_mem_arb.sv
// Shares the single VRAM port between SRC_RD, DST_RD and DST_WR burst requesters:
// round-robin with write-urgent override, outstanding read/write throttling and BUSY.
module drw_mem_arb #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned MAX_RD_OUT = 4,
  parameter int unsigned MAX_WR_OUT = 4
) (
  input  logic         CLK,
  input  logic         ARST,
  input  logic         SOFT_RST,
  drw_mem_arb_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ID_W  = 2;
  localparam logic [ID_W-1:0] ID_WR = ID_W'(2);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state_q, state_d;
  logic              m_req_q, m_req_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [LEN_W-1:0]  m_len_q, m_len_d;
  logic              m_write_q, m_write_d;
  logic [ID_W-1:0]   m_id_q, m_id_d;
  logic [ID_W-1:0]   last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

  logic [2:0]        elig;
  logic              rd_ok, wr_ok;
  logic [ID_W-1:0]   start, win, idx;
  logic              win_vld, found;
  logic              acked, rd_inc, wr_inc, rd_dec, wr_dec;
  logic [ADDR_W-1:0] win_addr;
  logic [LEN_W-1:0]  win_len;

  assign rd_ok = rd_cnt_q < CNT_W'(MAX_RD_OUT);
  assign wr_ok = wr_cnt_q < CNT_W'(MAX_WR_OUT);
  assign elig  = {bus.REQ[2] & wr_ok, bus.REQ[1] & rd_ok, bus.REQ[0] & rd_ok};
  assign start = (last_gnt_q == ID_W'(2)) ? ID_W'(0) : ID_W'(last_gnt_q + ID_W'(1));

  // Winner select: urgent write first, else first eligible from last_gnt+1
  always_comb begin
    win     = ID_W'(0);
    found   = 1'b0;
    idx     = ID_W'(0);
    win_vld = |elig;
    if (bus.WR_URGENT && elig[2]) begin
      win = ID_WR;
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        idx = ID_W'((32'(start) + k) % 32'd3);
        if (!found && elig[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end
  end

  always_comb begin
    case (win)
      ID_W'(0): begin win_addr = bus.ADDR0; win_len = bus.LEN0; end
      ID_W'(1): begin win_addr = bus.ADDR1; win_len = bus.LEN1; end
      default:  begin win_addr = bus.ADDR2; win_len = bus.LEN2; end
    endcase
  end

  assign acked  = (state_q == ISSUE) && bus.M_ACK;
  assign rd_dec = bus.M_RDONE && (rd_cnt_q != '0);
  assign wr_dec = bus.M_WDONE && (wr_cnt_q != '0);

  // Next-state, address-phase registers and outstanding counters
  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_addr_d   = m_addr_q;
    m_len_d    = m_len_q;
    m_write_d  = m_write_q;
    m_id_d     = m_id_q;
    last_gnt_d = last_gnt_q;
    rd_inc     = 1'b0;
    wr_inc     = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          m_req_d   = 1'b1;
          m_addr_d  = win_addr;
          m_len_d   = win_len;
          m_write_d = (win == ID_WR);
          m_id_d    = win;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.M_ACK) begin
          m_req_d    = 1'b0;
          last_gnt_d = m_id_q;
          rd_inc     = !m_write_q;
          wr_inc     = m_write_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    case ({rd_inc, rd_dec})
      2'b10:   rd_cnt_d = CNT_W'(rd_cnt_q + CNT_W'(1));
      2'b01:   rd_cnt_d = CNT_W'(rd_cnt_q - CNT_W'(1));
      default: rd_cnt_d = rd_cnt_q;
    endcase
    case ({wr_inc, wr_dec})
      2'b10:   wr_cnt_d = CNT_W'(wr_cnt_q + CNT_W'(1));
      2'b01:   wr_cnt_d = CNT_W'(wr_cnt_q - CNT_W'(1));
      default: wr_cnt_d = wr_cnt_q;
    endcase

    // Soft reset overrides everything, including a coincident ack
    if (SOFT_RST) begin
      state_d    = IDLE;
      m_req_d    = 1'b0;
      last_gnt_d = ID_WR;
      rd_cnt_d   = '0;
      wr_cnt_d   = '0;
    end
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state_q    <= IDLE;
      m_req_q    <= 1'b0;
      m_addr_q   <= '0;
      m_len_q    <= '0;
      m_write_q  <= 1'b0;
      m_id_q     <= '0;
      last_gnt_q <= ID_WR;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_addr_q   <= m_addr_d;
      m_len_q    <= m_len_d;
      m_write_q  <= m_write_d;
      m_id_q     <= m_id_d;
      last_gnt_q <= last_gnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign bus.M_REQ   = m_req_q;
  assign bus.M_ADDR  = m_addr_q;
  assign bus.M_LEN   = m_len_q;
  assign bus.M_WRITE = m_write_q;
  assign bus.M_ID    = m_id_q;
  assign bus.GNT     = (acked && !SOFT_RST) ? 3'(3'b001 << m_id_q) : 3'b000;
  assign bus.BUSY    = !ARST && ((state_q == ISSUE) || (|bus.REQ) ||
                                 (rd_cnt_q != '0) || (wr_cnt_q != '0));

endmodule

// File: tb/tb_drw_mem_arb.sv
// Directed bench for drw_mem_arb: expected bursts queued at request time, checked on each GNT.
module tb_drw_mem_arb;

  logic CLK      = 1'b0;
  logic ARST     = 1'b1;
  logic SOFT_RST = 1'b0;
  int   cycle    = 0;
  int   n_cmp    = 0;
  int   n_err    = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle++;

  drw_mem_arb_if #(.ADDR_W(32), .LEN_W(8)) bus ();

  drw_mem_arb #(.ADDR_W(32), .LEN_W(8), .MAX_RD_OUT(4), .MAX_WR_OUT(4)) dut (
    .CLK      (CLK),
    .ARST     (ARST),
    .SOFT_RST (SOFT_RST),
    .bus      (bus)
  );

  typedef struct {
    logic [1:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic        wr;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input int id);
    exp_t e;
    e.id = 2'(id);
    e.wr = (id == 2);
    case (id)
      0:       begin e.addr = bus.ADDR0; e.len = bus.LEN0; end
      1:       begin e.addr = bus.ADDR1; e.len = bus.LEN1; end
      default: begin e.addr = bus.ADDR2; e.len = bus.LEN2; end
    endcase
    sb.push_back(e);
  endtask

  // Wait for an address phase, hold it dly cycles, then ack (optionally with a read completion)
  task automatic ack_burst(input int dly, input logic rdone, output int ack_cyc);
    int t = 0;
    while (bus.M_REQ !== 1'b1 && t < 20) begin
      cyc();
      t++;
    end
    chk("m_req_seen", 64'(bus.M_REQ), 64'd1);
    repeat (dly) cyc();
    chk("m_req_held", 64'(bus.M_REQ), 64'd1);
    bus.M_ACK   = 1'b1;
    bus.M_RDONE = rdone;
    ack_cyc     = cycle;
    cyc();
    bus.M_ACK   = 1'b0;
    bus.M_RDONE = 1'b0;
  endtask

  // Grant monitor: every GNT pulse must match the oldest expected burst
  always @(negedge CLK) begin
    if (ARST === 1'b0 && bus.GNT !== 3'b000) begin
      if (sb.size() == 0) begin
        chk("unexpected_gnt", 64'(bus.GNT), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("gnt",     64'(bus.GNT),     64'(3'(3'b001 << e.id)));
        chk("m_id",    64'(bus.M_ID),    64'(e.id));
        chk("m_addr",  64'(bus.M_ADDR),  64'(e.addr));
        chk("m_len",   64'(bus.M_LEN),   64'(e.len));
        chk("m_write", 64'(bus.M_WRITE), 64'(e.wr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int c, prev;
    bus.REQ = 3'b000; bus.WR_URGENT = 1'b0;
    bus.M_ACK = 1'b0; bus.M_RDONE = 1'b0; bus.M_WDONE = 1'b0;
    bus.ADDR0 = 32'h2000_0100; bus.LEN0 = 8'd15;
    bus.ADDR1 = 32'h3000_0040; bus.LEN1 = 8'd7;
    bus.ADDR2 = 32'h4000_0800; bus.LEN2 = 8'd3;

    // Reset state
    #2;
    chk("rst_m_req", 64'(bus.M_REQ), 64'd0);
    chk("rst_gnt",   64'(bus.GNT),   64'd0);
    chk("rst_busy",  64'(bus.BUSY),  64'd0);
    #10 ARST = 1'b0;
    cyc();

    // Single read, acked after the request has been up 3 cycles
    bus.REQ = 3'b001; push(0);
    cyc();
    chk("rd_m_req",   64'(bus.M_REQ),   64'd1);
    chk("rd_m_addr",  64'(bus.M_ADDR),  64'h2000_0100);
    chk("rd_m_len",   64'(bus.M_LEN),   64'd15);
    chk("rd_m_write", 64'(bus.M_WRITE), 64'd0);
    ack_burst(2, 1'b0, c);
    bus.REQ = 3'b000;
    chk("rd_m_req_drop", 64'(bus.M_REQ), 64'd0);
    #1 chk("rd_busy_out", 64'(bus.BUSY), 64'd1);
    cyc();
    chk("rd_busy_hold", 64'(bus.BUSY), 64'd1);
    bus.M_RDONE = 1'b1;
    cyc();
    bus.M_RDONE = 1'b0;
    #1 chk("rd_busy_clear", 64'(bus.BUSY), 64'd0);

    // Round-robin from a fresh pointer
    SOFT_RST = 1'b1; cyc(); SOFT_RST = 1'b0;
    bus.REQ = 3'b111;
    for (int i = 0; i < 6; i++) push(i % 3);
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      ack_burst(0, 1'b0, c);
      if (i > 0) chk("rr_spacing", 64'(c - prev), 64'd2);
      prev = c;
    end
    bus.REQ = 3'b000;
    bus.M_RDONE = 1'b1; bus.M_WDONE = 1'b1;
    cyc(); cyc();
    bus.M_WDONE = 1'b0;
    cyc(); cyc();
    bus.M_RDONE = 1'b0;
    #1 chk("rr_drained", 64'(bus.BUSY), 64'd0);

    // Urgent write overrides round-robin, then pointer resumes at 0
    bus.REQ = 3'b111; bus.WR_URGENT = 1'b1; push(2);
    ack_burst(0, 1'b0, c);
    bus.WR_URGENT = 1'b0; push(0);
    ack_burst(0, 1'b0, c);
    bus.REQ = 3'b000;
    bus.M_RDONE = 1'b1; bus.M_WDONE = 1'b1;
    cyc();
    bus.M_RDONE = 1'b0; bus.M_WDONE = 1'b0;
    #1 chk("urg_drained", 64'(bus.BUSY), 64'd0);

    // Read throttle at four outstanding; write still flows
    bus.REQ = 3'b001;
    for (int i = 0; i < 4; i++) begin
      push(0);
      ack_burst(0, 1'b0, c);
    end
    bus.REQ = 3'b101; push(2);
    ack_burst(0, 1'b0, c);
    bus.REQ = 3'b001;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rd_throttled", 64'(bus.M_REQ), 64'd0);
    end
    bus.M_RDONE = 1'b1;
    cyc();
    bus.M_RDONE = 1'b0;
    chk("rd_done_edge", 64'(bus.M_REQ), 64'd0);
    cyc();
    chk("rd_after_done", 64'(bus.M_REQ), 64'd1);
    push(0);
    ack_burst(0, 1'b1, c);
    push(0);
    ack_burst(0, 1'b0, c);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rd_rethrottled", 64'(bus.M_REQ), 64'd0);
    end
    bus.REQ = 3'b000;
    bus.M_RDONE = 1'b1; bus.M_WDONE = 1'b1;
    cyc();
    cyc();
    bus.M_WDONE = 1'b0;
    repeat (3) cyc();
    bus.M_RDONE = 1'b0;
    #1 chk("thr_drained_sat", 64'(bus.BUSY), 64'd0);

    // Soft reset coincident with ack
    bus.REQ = 3'b001; push(0);
    ack_burst(0, 1'b0, c);
    cyc();
    chk("soft_m_req_up", 64'(bus.M_REQ), 64'd1);
    bus.M_ACK = 1'b1; SOFT_RST = 1'b1;
    #1 chk("soft_no_gnt", 64'(bus.GNT), 64'd0);
    cyc();
    bus.M_ACK = 1'b0; SOFT_RST = 1'b0; bus.REQ = 3'b000;
    chk("soft_m_req", 64'(bus.M_REQ), 64'd0);
    #1 chk("soft_busy", 64'(bus.BUSY), 64'd0);
    bus.REQ = 3'b011; push(0);
    ack_burst(0, 1'b0, c);
    bus.REQ = 3'b000;
    bus.M_RDONE = 1'b1;
    cyc();
    bus.M_RDONE = 1'b0;

    // Async reset mid-issue with three reads outstanding
    bus.REQ = 3'b001;
    for (int i = 0; i < 3; i++) begin
      push(0);
      ack_burst(0, 1'b0, c);
    end
    cyc();
    chk("arst_m_req_up", 64'(bus.M_REQ), 64'd1);
    ARST = 1'b1; bus.REQ = 3'b000;
    #1;
    chk("arst_m_req",   64'(bus.M_REQ),   64'd0);
    chk("arst_m_addr",  64'(bus.M_ADDR),  64'd0);
    chk("arst_m_len",   64'(bus.M_LEN),   64'd0);
    chk("arst_m_write", 64'(bus.M_WRITE), 64'd0);
    chk("arst_m_id",    64'(bus.M_ID),    64'd0);
    chk("arst_gnt",     64'(bus.GNT),     64'd0);
    chk("arst_busy",    64'(bus.BUSY),    64'd0);
    cyc(); cyc();
    ARST = 1'b0;
    cyc();
    chk("arst_cnt_zero", 64'(bus.BUSY), 64'd0);
    bus.REQ = 3'b100; push(2);
    ack_burst(0, 1'b0, c);
    bus.REQ = 3'b000;
    bus.M_WDONE = 1'b1;
    cyc();
    bus.M_WDONE = 1'b0;
    #1 chk("post_arst_busy", 64'(bus.BUSY), 64'd0);

    cyc();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/drw_mem_arb.md
# drw_mem_arb

Memory-port arbiter for the draw engine: shares the single external VRAM port between three burst requesters in the line datapath: texture source read, destination/background read, and destination write. It grants one burst address phase at a time using round-robin with a write-urgent override. It throttles outstanding reads and tracks outstanding writes. It reports BUSY so the main controller can drain memory traffic before asserting completion.

## Interface
- ADDR_W, 32, byte-address width
- LEN_W, 8, burst length field width (encoded beats-1)
- MAX_RD_OUT, 4, maximum outstanding read bursts (1..15)
- MAX_WR_OUT, 4, maximum outstanding write bursts (1..15)

- CLK  in  1  clock
- ARST  in  1  reset, asynchronous, active-high
- SOFT_RST  in  1  synchronous soft reset, active-high
- REQ  in  3  burst request; bit0 SRC_RD, bit1 DST_RD, bit2 DST_WR
- ADDR0/ADDR1/ADDR2  in  ADDR_W each  burst start address per requester
- LEN0/LEN1/LEN2  in  LEN_W each  burst length (beats-1) per requester
- GNT  out  3  one-hot grant pulse, at most one bit set
- WR_URGENT  in  1  write data buffer nearly full; write takes priority
- M_REQ  out  1  address-phase valid to memory port
- M_ADDR  out  ADDR_W  burst address
- M_LEN  out  LEN_W  burst length (beats-1)
- M_WRITE  out  1  1 = write burst
- M_ID  out  2  requester index 0..2
- M_ACK  in  1  memory accepts address phase (valid only while M_REQ=1)
- M_RDONE  in  1  pulse: one read burst fully returned
- M_WDONE  in  1  pulse: one write burst response received
- BUSY  out  1  any request, issue, or outstanding burst pending

## Operation
- States: IDLE, ISSUE.
- **Eligibility**
  - Read requester (bit0, bit1) is eligible when REQ set and rd_cnt < MAX_RD_OUT.
  - Write requester (bit2) is eligible when REQ set and wr_cnt < MAX_WR_OUT.
- **IDLE**
  - If any requester is eligible, select the winner, register M_ADDR/M_LEN/M_WRITE/M_ID from it, set M_REQ=1, and go to ISSUE.
  - Priority when WR_URGENT=1 and write is eligible: write wins.
  - Otherwise, round-robin starting from (last_gnt+1) mod 3.
- **ISSUE**
  - Hold all M_* outputs stable until M_ACK.
  - On the M_ACK cycle: GNT[M_ID]=1 (combinational from M_ACK & state==ISSUE), last_gnt<=M_ID, M_REQ<=0, increment the matching counter, go to IDLE.
- **Requester rule**
  - A requester holds REQ/ADDR/LEN stable until it sees GNT.
  - It must drop REQ, or present the next burst, in the cycle after GNT.
- **Counters**
  - rd_cnt and wr_cnt are 4 bits each.
  - Simultaneous increment (ack) and decrement (DONE) in one cycle leaves the count unchanged.
  - DONE arriving at count 0 is ignored; the count saturates at 0.
- **Outputs**
  - BUSY = (state==ISSUE) | (|REQ) | (rd_cnt!=0) | (wr_cnt!=0).
- **SOFT_RST**
  - Forces IDLE, M_REQ=0, counters=0, last_gnt=2.
  - An M_ACK in the same cycle is ignored: no GNT pulse and no counter change.
  - Takes priority over all other events.
- **Reset values** (ARST, all outputs)
  - M_REQ=0, M_ADDR=0, M_LEN=0, M_WRITE=0, M_ID=0, GNT=0, BUSY=0.
  - Internal: rd_cnt=0, wr_cnt=0, last_gnt=2 (so SRC_RD is first in round-robin).

## Timing
- REQ sampled in IDLE at cycle N gives M_REQ=1 at N+1.
- Earliest M_ACK is at N+1, with GNT in the same cycle.
- The arbiter is back in IDLE at N+2, so the minimum issue interval is 2 cycles.
- Arbitration decisions use REQ/WR_URGENT/counter values from the IDLE cycle only. Changes during ISSUE do not affect the pending burst.
- Counter updates from M_RDONE/M_WDONE are visible to eligibility the next cycle.
- Asserting ARST mid-ISSUE drops M_REQ immediately (asynchronously).

## Test plan
- **Single read:** REQ=001, ADDR0=0x2000_0100, LEN0=15, M_ACK 3 cycles after M_REQ.
  - Response: M_REQ held 3 cycles with M_ADDR=0x2000_0100, M_LEN=15, M_WRITE=0, M_ID=0.
  - GNT=001 on the ack cycle; rd_cnt=1; BUSY stays 1 until M_RDONE.
- **Round-robin:** REQ=111 held, WR_URGENT=0, M_ACK immediate.
  - Response: grant order 0,1,2,0,1,2 with a 2-cycle spacing.
- **Urgent write:** REQ=111, WR_URGENT=1 at the first IDLE.
  - Response: first grant is M_ID=2, M_WRITE=1.
  - WR_URGENT=0 afterward: next grant is 0.
- **Read throttle:** MAX_RD_OUT=4; four read bursts acked with no M_RDONE.
  - Response: fifth read is not issued, though write REQ=100 is still granted.
  - One M_RDONE pulse: read issues on the following cycle.
  - Simultaneous M_ACK (read) and M_RDONE: rd_cnt unchanged.
- **SOFT_RST mid-issue:** assert while M_REQ=1, coincident with M_ACK.
  - Response: no GNT, M_REQ=0 next cycle, counters=0, BUSY=0 if REQ=000.
- **ARST mid-operation:** assert with rd_cnt=3.
  - Response: all outputs at their reset values immediately; counters=0 after release.
